boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Boot-time copy engine. It is the read-side initiator for the boot ROM: it sweeps every ROM word in order and writes each one into main RAM at a fixed base address.
- It holds the CPU in reset-hold until the copy completes, then releases it.
- It keeps a running 16-bit checksum of all words copied, for boot self-test.
- It sits between the boot ROM, the RAM write port and the CPU hold input.

Parameters:
- ROM_AW, 5, ROM address width; ROM depth is 2**ROM_AW words.
- DW, 16, data word width.
- RAM_AW, 12, RAM address width.
- DEST_BASE, 0, RAM address for ROM word 0.
- AUTO_START, 1, 1 = start a copy automatically on the first clock after reset release; 0 = wait for start.

Ports:
- romclk  in  1  clock.
- rst  in  1  reset.
- start  in  1  request a copy; sampled at each rising edge.
- rom_cs  out  1  ROM chip select.
- rom_we  out  1  ROM write enable; tied 0.
- rom_addr  out  ROM_AW  ROM word address.
- rom_dout  in  DW  ROM read data.
- ram_cs  out  1  RAM select.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM write address.
- ram_din  out  DW  RAM write data.
- ram_ready  in  1  RAM accepts the write on this edge.
- busy  out  1  copy in progress.
- done  out  1  copy complete; sticky.
- cpu_hold  out  1  hold the CPU.
- checksum  out  DW  wrapping sum of the words copied.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is romclk. While rst is high, everything is forced to its reset value.
  - state = IDLE, idx = 0, data register = 0.
  - rom_cs = 0, rom_we = 0, rom_addr = 0.
  - ram_cs = 0, ram_we = 0, ram_addr = 0, ram_din = 0.
  - busy = 0, done = 0, checksum = 0, cpu_hold = 1.
- All outputs are registered.
- FSM states:
  - IDLE
    - Leave on a rising edge if start = 1, or if AUTO_START = 1 and this is the first edge after rst deasserts.
    - On leaving: idx = 0, checksum = 0, done = 0, busy = 1, cpu_hold = 1 → READ.
  - READ (1 cycle)
    - rom_cs = 1, rom_addr = idx.
    - Next edge → CAPTURE.
  - CAPTURE (1 cycle)
    - rom_cs stays 1 with the same rom_addr.
    - At the edge, data register <= rom_dout → WRITE.
  - WRITE
    - rom_cs = 0.
    - ram_cs = 1, ram_we = 1, ram_addr = DEST_BASE + idx (truncated to RAM_AW), ram_din = data.
    - Stays in WRITE with all outputs stable while ram_ready = 0.
    - On an edge with ram_ready = 1: checksum <= checksum + data (mod 2**DW).
      - If idx = 2**ROM_AW − 1 → DONE.
      - Otherwise idx + 1 → READ.
  - DONE
    - ram_cs = 0, ram_we = 0, busy = 0, done = 1, cpu_hold = 0.
    - start = 1 → same entry actions as from IDLE (restart).
- Latency:
  - 3 cycles per word when ram_ready is always high.
  - A full 32-word copy takes 96 cycles from the start edge to done = 1.
- Boundaries:
  - idx never wraps; the last word is checked before incrementing.
  - start while busy is ignored.
  - start and ram_ready together on the last word: the copy completes, and start is ignored on that edge.
  - rst mid-copy aborts the copy. No partial RAM write is left asserted. With AUTO_START = 1 the copy restarts from word 0.
  - ram_ready is ignored outside WRITE.
  - ROM reads are never issued with we = 1.

Test Plan:
- ROM model returns addr×0x0101, AUTO_START = 1, ram_ready = 1, DEST_BASE = 0x100.
  - RAM[0x100+i] = i×0x0101 for i = 0..31.
  - checksum = 0xF1F0.
  - done and cpu_hold = 0 exactly 96 cycles after reset release.
  - busy is high throughout the copy.
- ram_ready low for 5 cycles on word 7: ram_addr = 0x107 and ram_din = 0x0707 held stable; no idx advance; total time 101 cycles; checksum still 0xF1F0.
- rst asserted during word 12 of the copy: all outputs immediately at reset values; after release the copy restarts at word 0 and completes with the correct checksum.
- AUTO_START = 0:
  - No activity until start pulses (cpu_hold = 1 the whole time).
  - start during the copy is ignored.
  - start in DONE re-copies: checksum is cleared then rebuilt to 0xF1F0, and done drops for 96 cycles.
- ROM model returns 0xFFFF for every word: checksum wraps to 0xFFE0. rom_we = 0 on every cycle.
- ram_ready held high outside WRITE: no RAM writes other than the 32 valid ones, checked by counting ram_cs & ram_we edges.

Source files
------------

// File: rtl/boot_loader_if.sv
// Boot copy bus: ROM read port plus RAM write port seen from the copy engine.
// Latency: none, plain wires grouped for connection.
// Backpressure: ram_ready from the RAM side stalls a pending write.
interface boot_loader_if #(
   parameter int ROM_AW = 5,
   parameter int DW     = 16,
   parameter int RAM_AW = 12
) ();
   logic              rom_cs;
   logic              rom_we;
   logic [ROM_AW-1:0] rom_addr;
   logic [DW-1:0]     rom_dout;
   logic              ram_cs;
   logic              ram_we;
   logic [RAM_AW-1:0] ram_addr;
   logic [DW-1:0]     ram_din;
   logic              ram_ready;

   // Copy engine side: drives ROM address/select and the RAM write strobe.
   modport master (
      output rom_cs, rom_we, rom_addr,
      input  rom_dout,
      output ram_cs, ram_we, ram_addr, ram_din,
      input  ram_ready
   );

   // Memory side: returns ROM data and accepts RAM writes.
   modport slave (
      input  rom_cs, rom_we, rom_addr,
      output rom_dout,
      input  ram_cs, ram_we, ram_addr, ram_din,
      output ram_ready
   );
endinterface

// File: rtl/boot_loader.sv
// Boot copy engine: sweeps every ROM word into RAM at DEST_BASE, holds the CPU until done.
// Latency: 3 cycles per word (read, capture, write) when ram_ready stays high.
// Backpressure: ram_ready low freezes the WRITE state with all outputs held stable.
module boot_loader #(
   parameter int ROM_AW     = 5,
   parameter int DW         = 16,
   parameter int RAM_AW     = 12,
   parameter int DEST_BASE  = 0,
   parameter bit AUTO_START = 1'b1
) (
   input  logic          romclk,
   input  logic          rst,
   input  logic          start,
   boot_loader_if.master bus,
   output logic          busy,
   output logic          done,
   output logic          cpu_hold,
   output logic [DW-1:0] checksum
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      CAPTURE = 3'd2,
      WRITE   = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam logic [ROM_AW-1:0] LAST_IDX  = {ROM_AW{1'b1}};
   localparam logic [RAM_AW-1:0] BASE_ADDR = RAM_AW'(DEST_BASE);

   state_t            state;
   logic [ROM_AW-1:0] idx;
   logic [DW-1:0]     data;
   logic              first_edge;

   logic              rom_cs_q;
   logic [ROM_AW-1:0] rom_addr_q;
   logic              ram_cs_q;
   logic              ram_we_q;
   logic [RAM_AW-1:0] ram_addr_q;
   logic [DW-1:0]     ram_din_q;

   logic              launch;

   // Start a copy from IDLE (start, or the auto-start edge) or from DONE; never while busy.
   always_comb begin
      launch = 1'b0;
      if (state == IDLE) begin
         launch = start || (AUTO_START && first_edge);
      end else if (state == DONE) begin
         launch = start;
      end
   end

   // Copy FSM with every output registered; reset aborts any copy and drops the write strobe.
   always_ff @(posedge romclk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         data       <= '0;
         first_edge <= 1'b1;
         rom_cs_q   <= 1'b0;
         rom_addr_q <= '0;
         ram_cs_q   <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cpu_hold   <= 1'b1;
         checksum   <= '0;
      end else begin
         first_edge <= 1'b0;
         if (launch) begin
            idx        <= '0;
            checksum   <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            cpu_hold   <= 1'b1;
            rom_cs_q   <= 1'b1;
            rom_addr_q <= '0;
            ram_cs_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            state      <= READ;
         end else begin
            case (state)
               READ: begin
                  // Address was presented on entry; give the ROM one more cycle.
                  state <= CAPTURE;
               end
               CAPTURE: begin
                  data       <= bus.rom_dout;
                  rom_cs_q   <= 1'b0;
                  ram_cs_q   <= 1'b1;
                  ram_we_q   <= 1'b1;
                  ram_addr_q <= BASE_ADDR + RAM_AW'(idx);
                  ram_din_q  <= bus.rom_dout;
                  state      <= WRITE;
               end
               WRITE: begin
                  if (bus.ram_ready) begin
                     checksum <= checksum + data;
                     ram_cs_q <= 1'b0;
                     ram_we_q <= 1'b0;
                     // Last word is detected before incrementing so idx never wraps.
                     if (idx == LAST_IDX) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        state    <= DONE;
                     end else begin
                        idx        <= idx + ROM_AW'(1);
                        rom_cs_q   <= 1'b1;
                        rom_addr_q <= idx + ROM_AW'(1);
                        state      <= READ;
                     end
                  end
               end
               default: begin
                  // IDLE and DONE hold until a launch.
                  state <= state;
               end
            endcase
         end
      end
   end

   // ROM is read-only from here, so its write enable is a constant low.
   assign bus.rom_we   = 1'b0;
   assign bus.rom_cs   = rom_cs_q;
   assign bus.rom_addr = rom_addr_q;
   assign bus.ram_cs   = ram_cs_q;
   assign bus.ram_we   = ram_we_q;
   assign bus.ram_addr = ram_addr_q;
   assign bus.ram_din  = ram_din_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: one auto-start instance and one start-driven instance.
// Latency: checks exact edge counts (96 per copy, 101 with a 5-cycle stall).
// Backpressure: ram_ready is held low mid-copy to check the stalled write.
module tb_boot_loader;

   logic romclk = 1'b0;
   always #5 romclk = ~romclk;

   logic rst_a = 1'b1, rst_b = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0;
   logic ready_a = 1'b1, ready_b = 1'b1;
   logic rom_ones_a = 1'b0;

   logic        busy_a, done_a, hold_a, busy_b, done_b, hold_b;
   logic [15:0] sum_a, sum_b;

   int vectors = 0;
   int miscompares = 0;

   boot_loader_if #(.ROM_AW(5), .DW(16), .RAM_AW(12)) bus_a ();
   boot_loader_if #(.ROM_AW(5), .DW(16), .RAM_AW(12)) bus_b ();

   boot_loader #(.ROM_AW(5), .DW(16), .RAM_AW(12), .DEST_BASE('h100), .AUTO_START(1'b1)) dut_a (
      .romclk(romclk), .rst(rst_a), .start(start_a), .bus(bus_a),
      .busy(busy_a), .done(done_a), .cpu_hold(hold_a), .checksum(sum_a));

   boot_loader #(.ROM_AW(5), .DW(16), .RAM_AW(12), .DEST_BASE('h100), .AUTO_START(1'b0)) dut_b (
      .romclk(romclk), .rst(rst_b), .start(start_b), .bus(bus_b),
      .busy(busy_b), .done(done_b), .cpu_hold(hold_b), .checksum(sum_b));

   // ROM models: word at address a holds a*0x0101 (or all ones for the wrap test).
   assign bus_a.rom_dout  = rom_ones_a ? 16'hFFFF : 16'(bus_a.rom_addr) * 16'h0101;
   assign bus_b.rom_dout  = 16'(bus_b.rom_addr) * 16'h0101;
   assign bus_a.ram_ready = ready_a;
   assign bus_b.ram_ready = ready_b;

   logic [15:0] mem_a [0:4095];
   logic [15:0] mem_b [0:4095];
   int wr_a = 0, wr_b = 0, rom_we_bad = 0, act_b = 0;

   // RAM models: a write lands on an edge with cs, we and ready all high.
   always @(posedge romclk) begin
      if (bus_a.ram_cs && bus_a.ram_we && bus_a.ram_ready) begin
         mem_a[bus_a.ram_addr] <= bus_a.ram_din;
         wr_a <= wr_a + 1;
      end
      if (bus_b.ram_cs && bus_b.ram_we && bus_b.ram_ready) begin
         mem_b[bus_b.ram_addr] <= bus_b.ram_din;
         wr_b <= wr_b + 1;
      end
   end

   // Monitors: ROM write enable must never rise; count any activity on instance b.
   always @(negedge romclk) begin
      if (bus_a.rom_we !== 1'b0 || bus_b.rom_we !== 1'b0) rom_we_bad <= rom_we_bad + 1;
      if (bus_b.rom_cs || bus_b.ram_cs || busy_b || !hold_b) act_b <= act_b + 1;
   end

   logic [55:0] obs_a, obs_b;
   assign obs_a = {bus_a.rom_cs, bus_a.rom_we, bus_a.rom_addr, bus_a.ram_cs, bus_a.ram_we,
                   bus_a.ram_addr, bus_a.ram_din, busy_a, done_a, hold_a, sum_a};
   assign obs_b = {bus_b.rom_cs, bus_b.rom_we, bus_b.rom_addr, bus_b.ram_cs, bus_b.ram_we,
                   bus_b.ram_addr, bus_b.ram_din, busy_b, done_b, hold_b, sum_b};
   localparam logic [55:0] RESET_OBS = 56'h00_0000_0001_0000;

   task automatic test_reset();
      repeat (3) @(negedge romclk);
      vectors++;
      if (obs_a !== RESET_OBS) begin
         miscompares++; $display("FAIL reset_a: got %h expected %h", obs_a, RESET_OBS);
      end
      vectors++;
      if (obs_b !== RESET_OBS) begin
         miscompares++; $display("FAIL reset_b: got %h expected %h", obs_b, RESET_OBS);
      end
      rst_b = 1'b0;
   endtask

   task automatic test_full_copy();
      int base;
      int bad;
      base = wr_a;
      bad  = 0;
      rst_a = 1'b0;
      for (int k = 0; k < 96; k++) begin
         @(negedge romclk);
         if (busy_a !== 1'b1 || done_a !== 1'b0 || hold_a !== 1'b1) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++; $display("FAIL copy_busy_window: got %0d bad cycles expected 0", bad);
      end
      @(negedge romclk);
      vectors++;
      if ({busy_a, done_a, hold_a} !== 3'b010) begin
         miscompares++; $display("FAIL copy_done_at_96: got %b expected 010", {busy_a, done_a, hold_a});
      end
      vectors++;
      if (sum_a !== 16'hF1F0) begin
         miscompares++; $display("FAIL copy_checksum: got %h expected f1f0", sum_a);
      end
      for (int i = 0; i < 32; i++) begin
         logic [15:0] exp_w;
         exp_w = 16'(i * 16'h0101);
         vectors++;
         if (mem_a[12'h100 + 12'(i)] !== exp_w) begin
            miscompares++;
            $display("FAIL copy_ram_word %0d: got %h expected %h", i, mem_a[12'h100 + 12'(i)], exp_w);
         end
      end
      vectors++;
      if (wr_a - base != 32) begin
         miscompares++; $display("FAIL copy_write_count: got %0d expected 32", wr_a - base);
      end
   endtask

   task automatic test_stall();
      int base;
      int bad;
      bad = 0;
      @(negedge romclk) rst_a = 1'b1;
      @(negedge romclk) rst_a = 1'b0;
      base = wr_a;
      repeat (24) @(negedge romclk);
      vectors++;
      if ({bus_a.ram_cs, bus_a.ram_addr, bus_a.ram_din} !== {1'b1, 12'h107, 16'h0707}) begin
         miscompares++;
         $display("FAIL stall_entry: got %h/%h expected 107/0707", bus_a.ram_addr, bus_a.ram_din);
      end
      ready_a = 1'b0;
      repeat (5) begin
         @(negedge romclk);
         if ({bus_a.ram_cs, bus_a.ram_we, bus_a.ram_addr, bus_a.ram_din, bus_a.rom_addr}
             !== {1'b1, 1'b1, 12'h107, 16'h0707, 5'd7}) bad++;
      end
      ready_a = 1'b1;
      vectors++;
      if (bad != 0) begin
         miscompares++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad);
      end
      repeat (72) @(negedge romclk);
      vectors++;
      if (done_a !== 1'b0) begin
         miscompares++; $display("FAIL stall_done_early: got %b expected 0", done_a);
      end
      @(negedge romclk);
      vectors++;
      if ({done_a, sum_a} !== {1'b1, 16'hF1F0}) begin
         miscompares++; $display("FAIL stall_done_101: got %b/%h expected 1/f1f0", done_a, sum_a);
      end
      vectors++;
      if (wr_a - base != 32) begin
         miscompares++; $display("FAIL stall_write_count: got %0d expected 32", wr_a - base);
      end
   endtask

   task automatic test_reset_mid();
      int base;
      @(negedge romclk) rst_a = 1'b1;
      @(negedge romclk) rst_a = 1'b0;
      repeat (37) @(negedge romclk);
      vectors++;
      if ({bus_a.rom_cs, bus_a.rom_addr} !== {1'b1, 5'd12}) begin
         miscompares++; $display("FAIL mid_word12: got %b/%0d expected 1/12", bus_a.rom_cs, bus_a.rom_addr);
      end
      #2 rst_a = 1'b1;
      #1;
      vectors++;
      if (obs_a !== RESET_OBS) begin
         miscompares++; $display("FAIL mid_async_reset: got %h expected %h", obs_a, RESET_OBS);
      end
      @(negedge romclk) rst_a = 1'b0;
      base = wr_a;
      @(negedge romclk);
      vectors++;
      if ({bus_a.rom_cs, bus_a.rom_addr, busy_a} !== {1'b1, 5'd0, 1'b1}) begin
         miscompares++; $display("FAIL mid_restart_word0: got %b/%0d expected 1/0", bus_a.rom_cs, bus_a.rom_addr);
      end
      repeat (95) @(negedge romclk);
      vectors++;
      if (done_a !== 1'b0) begin
         miscompares++; $display("FAIL mid_done_early: got %b expected 0", done_a);
      end
      @(negedge romclk);
      vectors++;
      if ({done_a, sum_a} !== {1'b1, 16'hF1F0} || wr_a - base != 32) begin
         miscompares++;
         $display("FAIL mid_recopy: got done %b sum %h writes %0d expected 1 f1f0 32", done_a, sum_a, wr_a - base);
      end
   endtask

   task automatic test_wrap();
      rom_ones_a = 1'b1;
      @(negedge romclk) rst_a = 1'b1;
      @(negedge romclk) rst_a = 1'b0;
      repeat (97) @(negedge romclk);
      vectors++;
      if ({done_a, sum_a} !== {1'b1, 16'hFFE0}) begin
         miscompares++; $display("FAIL wrap_checksum: got %b/%h expected 1/ffe0", done_a, sum_a);
      end
      vectors++;
      if (mem_a[12'h11F] !== 16'hFFFF) begin
         miscompares++; $display("FAIL wrap_last_word: got %h expected ffff", mem_a[12'h11F]);
      end
      rom_ones_a = 1'b0;
   endtask

   task automatic test_start_mode();
      int bad;
      bad = 0;
      repeat (20) @(negedge romclk);
      vectors++;
      if (act_b != 0 || wr_b != 0) begin
         miscompares++; $display("FAIL idle_no_activity: got act %0d writes %0d expected 0 0", act_b, wr_b);
      end
      start_b = 1'b1;
      @(negedge romclk) start_b = 1'b0;
      vectors++;
      if ({busy_b, bus_b.rom_cs, hold_b} !== 3'b111) begin
         miscompares++; $display("FAIL start_launch: got %b expected 111", {busy_b, bus_b.rom_cs, hold_b});
      end
      repeat (40) @(negedge romclk);
      start_b = 1'b1;
      @(negedge romclk) start_b = 1'b0;
      repeat (54) @(negedge romclk);
      start_b = 1'b1;
      @(negedge romclk) start_b = 1'b0;
      vectors++;
      if ({busy_b, done_b, hold_b, sum_b} !== {3'b010, 16'hF1F0} || wr_b != 32) begin
         miscompares++;
         $display("FAIL busy_start_ignored: got %b sum %h writes %0d expected 010 f1f0 32",
                  {busy_b, done_b, hold_b}, sum_b, wr_b);
      end
      @(negedge romclk);
      vectors++;
      if ({busy_b, done_b} !== 2'b01) begin
         miscompares++; $display("FAIL last_edge_start_ignored: got %b expected 01", {busy_b, done_b});
      end
      start_b = 1'b1;
      @(negedge romclk) start_b = 1'b0;
      vectors++;
      if ({busy_b, done_b, hold_b, sum_b} !== {3'b101, 16'h0000}) begin
         miscompares++; $display("FAIL restart_clear: got %b sum %h expected 101 0000", {busy_b, done_b, hold_b}, sum_b);
      end
      repeat (95) begin
         @(negedge romclk);
         if (done_b !== 1'b0 || hold_b !== 1'b1) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++; $display("FAIL restart_done_low: got %0d bad cycles expected 0", bad);
      end
      @(negedge romclk);
      vectors++;
      if ({done_b, sum_b} !== {1'b1, 16'hF1F0} || wr_b != 64) begin
         miscompares++; $display("FAIL restart_complete: got %b sum %h writes %0d expected 1 f1f0 64", done_b, sum_b, wr_b);
      end
      vectors++;
      if (mem_b[12'h11E] !== 16'h1E1E) begin
         miscompares++; $display("FAIL restart_ram_word: got %h expected 1e1e", mem_b[12'h11E]);
      end
   endtask

   task automatic test_rom_we();
      vectors++;
      if (rom_we_bad != 0) begin
         miscompares++; $display("FAIL rom_we_low: got %0d cycles high expected 0", rom_we_bad);
      end
   endtask

   initial begin
      test_reset();
      test_full_copy();
      test_stall();
      test_reset_mid();
      test_wrap();
      test_start_mode();
      test_rom_we();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
